// File: rtl/mixcol_column_sequencer.sv
// Column-serial AES MixColumns: one shared 32-bit column unit processes the
// four state columns over four cycles. Inverse mode is built only with MIXCOL_INV_EN.
module mixcol_column_sequencer (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
`ifdef MIXCOL_INV_EN
    input  logic         inv,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic [127:0]  work_r;
    logic [1:0]    col_cnt_r;
    logic          accept_s;
    logic [31:0]   col_in_s;
    logic [31:0]   col_out_s;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Row 0 sits in the most significant byte of each column word.
    function automatic logic [31:0] mix_fwd(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] d0, d1, d2, d3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        d0 = xtime(a0);
        d1 = xtime(a1);
        d2 = xtime(a2);
        d3 = xtime(a3);
        return {d0 ^ d1 ^ a1 ^ a2 ^ a3,
                a0 ^ d1 ^ d2 ^ a2 ^ a3,
                a0 ^ a1 ^ d2 ^ d3 ^ a3,
                d0 ^ a0 ^ a1 ^ a2 ^ d3};
    endfunction

`ifdef MIXCOL_INV_EN
    // x9/x11/x13/x14 come from the x2, x4, x8 chain of each byte.
    function automatic logic [31:0] mix_inv(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] m2 [4];
        logic [7:0] m4 [4];
        logic [7:0] m8 [4];
        logic [7:0] m9 [4];
        logic [7:0] m11 [4];
        logic [7:0] m13 [4];
        logic [7:0] m14 [4];
        a[0] = c[31:24];
        a[1] = c[23:16];
        a[2] = c[15:8];
        a[3] = c[7:0];
        for (int i = 0; i < 4; i++) begin
            m2[i]  = xtime(a[i]);
            m4[i]  = xtime(m2[i]);
            m8[i]  = xtime(m4[i]);
            m9[i]  = m8[i] ^ a[i];
            m11[i] = m8[i] ^ m2[i] ^ a[i];
            m13[i] = m8[i] ^ m4[i] ^ a[i];
            m14[i] = m8[i] ^ m4[i] ^ m2[i];
        end
        return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
                m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
                m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
                m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
    endfunction
`endif

    assign accept_s  = in_valid && in_ready;
    assign state_out = work_r;

    // Select the column currently being processed.
    always_comb begin
        col_in_s = work_r[{col_cnt_r, 5'b00000} +: 32];
    end

`ifdef MIXCOL_INV_EN
    logic mode_r;

    // Forward or inverse column transform, chosen by the captured mode.
    always_comb begin
        col_out_s = 32'h0000_0000;
        if (mode_r) begin
            col_out_s = mix_inv(col_in_s);
        end else begin
            col_out_s = mix_fwd(col_in_s);
        end
    end

    // Mode is latched once per state so later inv changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r <= 1'b0;
        end else if ((state_r == IDLE) && accept_s) begin
            mode_r <= inv;
        end
    end
`else
    // Forward column transform only.
    always_comb begin
        col_out_s = mix_fwd(col_in_s);
    end
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; DONE never reloads in the same cycle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (col_cnt_r == 2'd3) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Status outputs are registered copies of the next state decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            in_ready  <= (state_next_s == IDLE);
            out_valid <= (state_next_s == DONE);
            busy      <= (state_next_s != IDLE);
        end
    end

    // Work register: load on accept, then overwrite one column per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_r    <= 128'h0;
            col_cnt_r <= 2'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        work_r    <= state_in;
                        col_cnt_r <= 2'd0;
                    end
                end
                RUN: begin
                    work_r[{col_cnt_r, 5'b00000} +: 32] <= col_out_s;
                    col_cnt_r <= col_cnt_r + 2'd1;
                end
                default: begin
                    col_cnt_r <= col_cnt_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mixcol_column_sequencer.sv
// Bench for mixcol_column_sequencer: vector table with a queue scoreboard plus
// backpressure, back-to-back, mid-run reset and (with MIXCOL_INV_EN) inverse cases.
module tb_mixcol_column_sequencer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [127:0] exp_q[$];

    typedef struct {
        logic [127:0] din;
        logic         inv;
        logic [127:0] dout;
    } vec_t;

    vec_t tbl[5];

    always #5 clk = ~clk;

    mixcol_column_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
`ifdef MIXCOL_INV_EN
        .inv       (inv),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .busy      (busy)
    );

    // Generic GF(2^8) multiply by shift-and-add.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] mix_ref(input logic [127:0] s, input logic m);
        logic [7:0]   cf[4];
        logic [7:0]   a[4];
        logic [7:0]   r;
        logic [127:0] res;
        if (m) begin
            cf[0] = 8'd14; cf[1] = 8'd11; cf[2] = 8'd13; cf[3] = 8'd9;
        end else begin
            cf[0] = 8'd2;  cf[1] = 8'd3;  cf[2] = 8'd1;  cf[3] = 8'd1;
        end
        res = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = s[c*32 + 24 - 8*j +: 8];
            for (int j = 0; j < 4; j++) begin
                r = 8'h00;
                for (int k = 0; k < 4; k++) r = r ^ gmul(a[k], cf[(k - j + 4) % 4]);
                res[c*32 + 24 - 8*j +: 8] = r;
            end
        end
        return res;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic do_accept(input logic [127:0] s, input logic iv, input logic [127:0] e);
        int w;
        w = 0;
        state_in = s;
        inv      = iv;
        in_valid = 1'b1;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("accept_ready", {127'h0, in_ready}, 128'h1);
        if (in_ready) begin
            @(posedge clk);
            exp_q.push_back(e);
            @(negedge clk);
            in_valid = 1'b0;
            state_in = {$urandom, $urandom, $urandom, $urandom};
            inv      = 1'($urandom);
            chk("run_busy", {126'h0, busy, in_ready}, 128'h2);
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_result(input string name);
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({name, "_latency"}, 128'(lat), 128'd4);
    endtask

    task automatic take_result(input string name);
        logic [127:0] e;
        out_ready = 1'b1;
        chk({name, "_sb_nonempty"}, 128'(exp_q.size() > 0), 128'h1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({name, "_data"}, state_out, e);
        end
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, "_idle_after"}, {125'h0, in_ready, out_valid, busy}, 128'h4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] v1, v2;
        int acc_k[2];
        int n_acc;
        int n_out;

        tbl[0].din = 128'hdb135345_f20a225c_01010101_2d26314c;
        tbl[0].inv = 1'b0;
        tbl[0].dout = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
        tbl[1].din = 128'hc6c6c6c6_d4d4d4d5_00000000_ffffffff;
        tbl[1].inv = 1'b0;
        tbl[1].dout = 128'hc6c6c6c6_d5d5d7d6_00000000_ffffffff;
        for (int i = 2; i < 5; i++) begin
            tbl[i].din  = {$urandom, $urandom, $urandom, $urandom};
            tbl[i].inv  = 1'b0;
            tbl[i].dout = mix_ref(tbl[i].din, 1'b0);
        end

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; state_in = 128'h0; inv = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {127'h0, in_ready}, 128'h1);
        chk("rst_out_valid", {127'h0, out_valid}, 128'h0);
        chk("rst_busy", {127'h0, busy}, 128'h0);
        chk("rst_state_out", state_out, 128'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            do_accept(tbl[i].din, tbl[i].inv, tbl[i].dout);
            wait_result($sformatf("vec%0d", i));
            take_result($sformatf("vec%0d", i));
        end

        // Backpressure: DONE holds while upstream keeps poking.
        do_accept(tbl[0].din, 1'b0, tbl[0].dout);
        wait_result("bp");
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'(i % 2);
            state_in = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk("bp_stable", state_out, tbl[0].dout);
            chk("bp_flags", {125'h0, in_ready, out_valid, busy}, 128'h3);
        end
        in_valid = 1'b0;
        take_result("bp");

        // Back-to-back with in_valid and out_ready held high.
        v1 = tbl[1].din;
        v2 = tbl[3].din;
        out_ready = 1'b1; in_valid = 1'b1; state_in = v1;
        n_acc = 0; n_out = 0; acc_k[0] = 0; acc_k[1] = 0;
        for (int k = 0; k < 30 && n_out < 2; k++) begin
            if (n_acc == 1) state_in = v2;
            else if (n_acc >= 2) in_valid = 1'b0;
            if (in_valid && in_ready && n_acc < 2) begin
                acc_k[n_acc] = k;
                exp_q.push_back(mix_ref(n_acc == 0 ? v1 : v2, 1'b0));
                n_acc++;
            end
            if (out_valid && out_ready) begin
                chk("b2b_sb_nonempty", 128'(exp_q.size() > 0), 128'h1);
                if (exp_q.size() > 0) chk("b2b_data", state_out, exp_q.pop_front());
                n_out++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b_accepts", 128'(n_acc), 128'd2);
        chk("b2b_gap", 128'(acc_k[1] - acc_k[0]), 128'd6);
        chk("b2b_outputs", 128'(n_out), 128'd2);

        // Reset two cycles into RUN discards the partial result.
        do_accept(tbl[2].din, 1'b0, tbl[2].dout);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_flags", {125'h0, in_ready, out_valid, busy}, 128'h4);
        chk("mid_rst_state_out", state_out, 128'h0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_accept(tbl[0].din, 1'b0, tbl[0].dout);
        wait_result("post_rst");
        take_result("post_rst");

`ifdef MIXCOL_INV_EN
        do_accept(128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, 1'b1,
                  128'hdb135345_f20a225c_01010101_2d26314c);
        wait_result("inv_vec");
        take_result("inv_vec");
        do_accept(tbl[4].din, 1'b1, mix_ref(tbl[4].din, 1'b1));
        wait_result("inv_rand");
        take_result("inv_rand");
        do_accept(tbl[3].din, 1'b0, tbl[3].dout);
        wait_result("fwd_after_inv");
        take_result("fwd_after_inv");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
